maze_follower: RTL and testbench

MAZE_FOLLOWER -- requirements
Module: maze_follower

---
 rtl/maze_follower_pkg.sv | 38 +++
 rtl/maze_step_calc.sv | 49 ++++
 rtl/maze_follower.sv | 201 ++++++++++++++++++++
 tb/tb_maze_follower.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_follower_pkg.sv
// Shared definitions for the wall-following maze solver.
// Contents:
//   dir_e       - heading encoding UP=0, LEFT=1, DOWN=2, RIGHT=3
//                 (+1 is a counter-clockwise turn)
//   state_e     - controller states IDLE, MARK, PROBE, CHECK, DONE, FAIL
//   turn_toward - rotate a heading one step toward the followed hand
//   turn_away   - rotate a heading one step away from the followed hand
package maze_follower_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MARK  = 3'd1,
    PROBE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    FAIL  = 3'd5
  } state_e;

  localparam logic HAND_RIGHT = 1'b0;
  localparam logic HAND_LEFT  = 1'b1;

  // Right hand: a right turn is clockwise (-1); left hand: counter-clockwise (+1).
  function automatic dir_e turn_toward(input dir_e d, input logic hand);
    return (hand == HAND_LEFT) ? dir_e'(d + 2'd1) : dir_e'(d - 2'd1);
  endfunction

  function automatic dir_e turn_away(input dir_e d, input logic hand);
    return (hand == HAND_LEFT) ? dir_e'(d - 2'd1) : dir_e'(d + 2'd1);
  endfunction

endpackage

// File: rtl/maze_step_calc.sv
// Neighbour coordinate calculator (purely combinational).
// Ports:
//   row_i, col_i   - current cell
//   dir_i          - direction to look (dir_e encoding)
//   nrow_o, ncol_o - neighbour cell in that direction (wraps when out of range)
//   oob_o          - neighbour lies outside 0..MAZE_SIZE-1
module maze_step_calc
  import maze_follower_pkg::*;
#(
  parameter int MAZE_WIDTH = 6,
  parameter int MAZE_SIZE  = 64
) (
  input  logic [MAZE_WIDTH-1:0] row_i,
  input  logic [MAZE_WIDTH-1:0] col_i,
  input  logic [1:0]            dir_i,
  output logic [MAZE_WIDTH-1:0] nrow_o,
  output logic [MAZE_WIDTH-1:0] ncol_o,
  output logic                  oob_o
);

  localparam logic [MAZE_WIDTH-1:0] LAST = MAZE_WIDTH'(MAZE_SIZE - 1);
  localparam logic [MAZE_WIDTH-1:0] ONE  = MAZE_WIDTH'(1);

  always_comb begin
    nrow_o = row_i;
    ncol_o = col_i;
    oob_o  = 1'b0;
    case (dir_e'(dir_i))
      UP: begin
        nrow_o = row_i - ONE;
        oob_o  = (row_i == '0);
      end
      DOWN: begin
        nrow_o = row_i + ONE;
        oob_o  = (row_i >= LAST);
      end
      LEFT: begin
        ncol_o = col_i - ONE;
        oob_o  = (col_i == '0);
      end
      RIGHT: begin
        ncol_o = col_i + ONE;
        oob_o  = (col_i >= LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/maze_follower.sv
// Wall-following maze solver driving an external 1-bit maze memory.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   start, hand                - run request; 0 = right-hand rule, 1 = left-hand
//   starting_row, starting_col - start cell, sampled on an accepted start
//   maze_in                    - wall bit, valid the cycle after maze_oe
//   row, col, maze_oe, maze_we - memory address, read enable, visit-mark write
//   done, fail, step_count     - exit found, search aborted, completed moves
// All outputs come straight from registers.
module maze_follower
  import maze_follower_pkg::*;
#(
  parameter int MAZE_WIDTH = 6,
  parameter int MAZE_SIZE  = 64,
  parameter int STEP_W     = 16,
  parameter int MAX_STEPS  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hand,
  input  logic [MAZE_WIDTH-1:0] starting_row,
  input  logic [MAZE_WIDTH-1:0] starting_col,
  input  logic                  maze_in,
  output logic [MAZE_WIDTH-1:0] row,
  output logic [MAZE_WIDTH-1:0] col,
  output logic                  maze_oe,
  output logic                  maze_we,
  output logic                  done,
  output logic                  fail,
  output logic [STEP_W-1:0]     step_count
);

  localparam logic [MAZE_WIDTH-1:0] LAST     = MAZE_WIDTH'(MAZE_SIZE - 1);
  localparam logic [STEP_W-1:0]     MAX_S    = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0]     STEP_ONE = STEP_W'(1);

  state_e                  state_q, state_d;
  logic [MAZE_WIDTH-1:0]   row_q, row_d, col_q, col_d;
  logic                    oe_q, oe_d, we_q, we_d, done_q, done_d, fail_q, fail_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [2:0]              walls_q, walls_d;
  dir_e                    heading_q, heading_d, pdir_q, pdir_d;
  logic                    hand_q, hand_d, probe_oob_q, probe_oob_d;
  logic [MAZE_WIDTH-1:0]   cur_row_q, cur_row_d, cur_col_q, cur_col_d;

  dir_e                    calc_dir;
  logic [MAZE_WIDTH-1:0]   nb_row, nb_col;
  logic                    nb_oob, wall, at_exit;

  // The next probe address is computed one cycle early so it can be registered:
  // from MARK the first probe turns toward the hand, from CHECK a wall rotates away.
  always_comb begin
    calc_dir = pdir_q;
    if (state_q == MARK)       calc_dir = turn_toward(heading_q, hand_q);
    else if (state_q == CHECK) calc_dir = turn_away(pdir_q, hand_q);
  end

  maze_step_calc #(
    .MAZE_WIDTH (MAZE_WIDTH),
    .MAZE_SIZE  (MAZE_SIZE)
  ) u_step (
    .row_i  (cur_row_q),
    .col_i  (cur_col_q),
    .dir_i  (calc_dir),
    .nrow_o (nb_row),
    .ncol_o (nb_col),
    .oob_o  (nb_oob)
  );

  // Out-of-range neighbours were never read; they count as walls.
  assign wall    = probe_oob_q | maze_in;
  assign at_exit = (cur_row_q == '0) || (cur_row_q == LAST) ||
                   (cur_col_q == '0) || (cur_col_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      step_q    <= '0;
      walls_q   <= '0;
      heading_q <= DOWN;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      step_q    <= step_d;
      walls_q   <= walls_d;
      heading_q <= heading_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_row_q   <= cur_row_d;
    cur_col_q   <= cur_col_d;
    pdir_q      <= pdir_d;
    hand_q      <= hand_d;
    probe_oob_q <= probe_oob_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, FAIL: if (start) state_d = MARK;
      // MARK also writes each newly entered cell; the start cell (no moves yet)
      // never counts as an exit.
      MARK: begin
        if (step_q == '0)      state_d = PROBE;
        else if (at_exit)      state_d = DONE;
        else if (step_q >= MAX_S) state_d = FAIL;
        else                   state_d = PROBE;
      end
      PROBE: state_d = CHECK;
      CHECK: begin
        if (!wall)                 state_d = MARK;
        else if (walls_q == 3'd3)  state_d = FAIL;
        else                       state_d = PROBE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    oe_d        = 1'b0;
    we_d        = 1'b0;
    done_d      = done_q;
    fail_d      = fail_q;
    step_d      = step_q;
    walls_d     = walls_q;
    heading_d   = heading_q;
    pdir_d      = pdir_q;
    hand_d      = hand_q;
    probe_oob_d = probe_oob_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          cur_row_d = starting_row;
          cur_col_d = starting_col;
          hand_d    = hand;
          heading_d = DOWN;
          step_d    = '0;
          walls_d   = '0;
          done_d    = 1'b0;
          fail_d    = 1'b0;
          row_d     = starting_row;
          col_d     = starting_col;
          we_d      = 1'b1;
        end
      end
      CHECK: begin
        if (wall) begin
          walls_d = walls_q + 3'd1;
        end else begin
          // row_q/col_q still hold the probed cell, which becomes the new position.
          cur_row_d = row_q;
          cur_col_d = col_q;
          heading_d = pdir_q;
          step_d    = (step_q == '1) ? step_q : step_q + STEP_ONE;
          walls_d   = '0;
          we_d      = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == PROBE) begin
      pdir_d      = calc_dir;
      row_d       = nb_row;
      col_d       = nb_col;
      oe_d        = ~nb_oob;
      probe_oob_d = nb_oob;
    end
    if (state_d == DONE && state_q != DONE) done_d = 1'b1;
    if (state_d == FAIL && state_q != FAIL) begin
      fail_d = 1'b1;
      row_d  = cur_row_q;
      col_d  = cur_col_q;
    end
  end

  assign row        = row_q;
  assign col        = col_q;
  assign maze_oe    = oe_q;
  assign maze_we    = we_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_maze_follower.sv
module tb_maze_follower;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // main instance (default MAX_STEPS) and a MAX_STEPS=16 instance
  logic       start_m, hand_m, maze_in_m, oe_m, we_m, done_m, fail_m;
  logic [5:0] srow_m, scol_m, row_m, col_m;
  logic [15:0] step_m;
  logic       start_s, hand_s, maze_in_s, oe_s, we_s, done_s, fail_s;
  logic [5:0] srow_s, scol_s, row_s, col_s;
  logic [15:0] step_s;

  logic maze_mem [0:63][0:63];
  logic rd_m = 1'b1, rd_s = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  int q_m[$];
  int q_s[$];
  int oe_cnt_m = 0;

  maze_follower u_dut (
    .clk(clk), .rst(rst), .start(start_m), .hand(hand_m),
    .starting_row(srow_m), .starting_col(scol_m), .maze_in(maze_in_m),
    .row(row_m), .col(col_m), .maze_oe(oe_m), .maze_we(we_m),
    .done(done_m), .fail(fail_m), .step_count(step_m)
  );

  maze_follower #(.MAX_STEPS(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_s), .hand(hand_s),
    .starting_row(srow_s), .starting_col(scol_s), .maze_in(maze_in_s),
    .row(row_s), .col(col_s), .maze_oe(oe_s), .maze_we(we_s),
    .done(done_s), .fail(fail_s), .step_count(step_s)
  );

  // synchronous-read maze memories
  always @(posedge clk) if (oe_m) rd_m <= maze_mem[row_m][col_m];
  always @(posedge clk) if (oe_s) rd_s <= maze_mem[row_s][col_s];
  assign maze_in_m = rd_m;
  assign maze_in_s = rd_s;

  task automatic chk(input string tag, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  // scoreboard monitors: every write must match the next expected cell
  always @(negedge clk) begin
    if (we_m) begin
      if (q_m.size() == 0) chk("we_extra_main", int'(row_m) * 64 + int'(col_m), -1);
      else chk("we_addr_main", int'(row_m) * 64 + int'(col_m), q_m.pop_front());
    end
    if (oe_m) oe_cnt_m++;
    if (oe_m && we_m) chk("oe_we_excl_main", 1, 0);
  end

  always @(negedge clk) begin
    if (we_s) begin
      if (q_s.size() == 0) chk("we_extra_16", int'(row_s) * 64 + int'(col_s), -1);
      else chk("we_addr_16", int'(row_s) * 64 + int'(col_s), q_s.pop_front());
    end
    if (oe_s && we_s) chk("oe_we_excl_16", 1, 0);
  end

  task automatic push_m(input int r, input int c);
    q_m.push_back(r * 64 + c);
  endtask

  task automatic push_s(input int r, input int c);
    q_s.push_back(r * 64 + c);
  endtask

  task automatic fill_walls();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        maze_mem[r][c] = 1'b1;
  endtask

  // Issue a start, then wait (bounded) for done/fail. n = edges after the accept edge.
  task automatic run(input bit sel, input int r, input int c, input bit h,
                     input int budget, input int poke_at, output int n);
    @(negedge clk);
    if (sel) begin
      start_s = 1'b1; srow_s = 6'(r); scol_s = 6'(c); hand_s = h;
    end else begin
      start_m = 1'b1; srow_m = 6'(r); scol_m = 6'(c); hand_m = h;
    end
    @(negedge clk);
    start_m = 1'b0;
    start_s = 1'b0;
    n = 0;
    chk("mark_no_done", sel ? int'(done_s) : int'(done_m), 0);
    while ((sel ? !(done_s || fail_s) : !(done_m || fail_m)) && n < budget) begin
      if (n == poke_at) begin
        start_m = 1'b1; srow_m = 6'd40; scol_m = 6'd40; hand_m = 1'b1;
      end else begin
        start_m = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start_m = 1'b0;
    chk("finish_in_budget", int'(n < budget), 1);
  endtask

  initial begin
    int n;
    int oe_before;
    rst = 1'b1;
    start_m = 1'b0; hand_m = 1'b0; srow_m = '0; scol_m = '0;
    start_s = 1'b0; hand_s = 1'b0; srow_s = '0; scol_s = '0;
    fill_walls();
    repeat (3) @(negedge clk);
    chk("rst_row", row_m, 0);
    chk("rst_col", col_m, 0);
    chk("rst_oe", oe_m, 0);
    chk("rst_we", we_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_fail", fail_m, 0);
    chk("rst_step", step_m, 0);
    rst = 1'b0;

    // straight corridor in column 5, with a start pulse while busy
    fill_walls();
    for (int r = 1; r < 64; r++) begin
      maze_mem[r][5] = 1'b0;
      push_m(r, 5);
    end
    run(1'b0, 1, 5, 1'b0, 2000, 10, n);
    chk("corr_done", done_m, 1);
    chk("corr_fail", fail_m, 0);
    chk("corr_step", step_m, 62);
    chk("corr_row", row_m, 63);
    chk("corr_col", col_m, 5);
    chk("corr_sb_empty", q_m.size(), 0);

    // reset while in CHECK, then a clean restart
    push_m(1, 5);
    @(negedge clk);
    start_m = 1'b1; srow_m = 6'd1; scol_m = 6'd5; hand_m = 1'b0;
    @(negedge clk);        // MARK
    start_m = 1'b0;
    @(negedge clk);        // PROBE
    @(negedge clk);        // CHECK
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_row", row_m, 0);
    chk("rstmid_col", col_m, 0);
    chk("rstmid_oe", oe_m, 0);
    chk("rstmid_we", we_m, 0);
    chk("rstmid_done", done_m, 0);
    chk("rstmid_fail", fail_m, 0);
    chk("rstmid_step", step_m, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_oe_after", oe_m, 0);
    for (int r = 30; r < 64; r++) push_m(r, 5);
    run(1'b0, 30, 5, 1'b0, 2000, -1, n);
    chk("restart_done", done_m, 1);
    chk("restart_step", step_m, 33);
    chk("restart_sb_empty", q_m.size(), 0);

    // enclosed cell
    fill_walls();
    push_m(10, 10);
    oe_before = oe_cnt_m;
    run(1'b0, 10, 10, 1'b0, 200, -1, n);
    chk("encl_cycles", n, 9);
    chk("encl_fail", fail_m, 1);
    chk("encl_done", done_m, 0);
    chk("encl_step", step_m, 0);
    chk("encl_oe_count", oe_cnt_m - oe_before, 4);
    chk("encl_row", row_m, 10);
    chk("encl_col", col_m, 10);

    // enclosed corner: two of the four probes are off the maze
    push_m(0, 0);
    oe_before = oe_cnt_m;
    run(1'b0, 0, 0, 1'b0, 200, -1, n);
    chk("corner_cycles", n, 9);
    chk("corner_fail", fail_m, 1);
    chk("corner_oe_count", oe_cnt_m - oe_before, 2);
    chk("corner_row", row_m, 0);
    chk("corner_col", col_m, 0);
    chk("corner_sb_empty", q_m.size(), 0);

    // T-junction: row 5 fully open
    fill_walls();
    for (int c = 0; c < 64; c++) maze_mem[5][c] = 1'b0;
    for (int c = 5; c >= 0; c--) push_m(5, c);
    run(1'b0, 5, 5, 1'b0, 2000, -1, n);
    chk("tright_done", done_m, 1);
    chk("tright_step", step_m, 5);
    chk("tright_col", col_m, 0);
    chk("tright_sb_empty", q_m.size(), 0);
    for (int c = 5; c < 64; c++) push_m(5, c);
    run(1'b0, 5, 5, 1'b1, 2000, -1, n);
    chk("tleft_done", done_m, 1);
    chk("tleft_step", step_m, 58);
    chk("tleft_col", col_m, 63);
    chk("tleft_sb_empty", q_m.size(), 0);

    // start on the boundary: must move before an exit counts
    fill_walls();
    maze_mem[0][7] = 1'b0;
    maze_mem[1][7] = 1'b0;
    push_m(0, 7); push_m(1, 7); push_m(0, 7);
    run(1'b0, 0, 7, 1'b0, 500, -1, n);
    chk("bnd_done", done_m, 1);
    chk("bnd_step", step_m, 2);
    chk("bnd_row", row_m, 0);
    chk("bnd_col", col_m, 7);
    chk("bnd_sb_empty", q_m.size(), 0);

    // 2x2 loop on the MAX_STEPS=16 instance
    fill_walls();
    maze_mem[10][10] = 1'b0; maze_mem[10][11] = 1'b0;
    maze_mem[11][10] = 1'b0; maze_mem[11][11] = 1'b0;
    push_s(10, 10);
    for (int k = 0; k < 4; k++) begin
      push_s(11, 10); push_s(11, 11); push_s(10, 11); push_s(10, 10);
    end
    run(1'b1, 10, 10, 1'b0, 2000, -1, n);
    chk("loop_fail", fail_s, 1);
    chk("loop_done", done_s, 0);
    chk("loop_step", step_s, 16);
    repeat (10) @(negedge clk);
    chk("loop_sb_empty", q_s.size(), 0);
    chk("loop_step_held", step_s, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
